mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multicycle signed multiply/divide unit with architectural Hi and Lo registers for the multicycle MIPS datapath. It takes operands from the A and B registers and runs a 32-iteration shift-add multiply or a restoring divide. It holds the 64-bit result internally until the controller commits it to Hi/Lo. Hi and Lo drive the Hi/Lo inputs of the MemtoReg mux, and div_zero is reported to the controller for exception handling.

## Interface
- No parameters; datapath width is fixed at 32 bits.
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  begin operation; sampled only in IDLE or DONE
- op  input  1  operation select (DivOrM): 0 = mult, 1 = div
- a  input  32  operand A / dividend (RegA output)
- b  input  32  operand B / divisor (RegB output)
- hilo_write  input  1  commit result registers into Hi/Lo (HiLoWrite)
- busy  output  1  high while iterating (MULT or DIV state)
- done  output  1  one-cycle pulse; result registers valid
- div_zero  output  1  last started div had b == 0
- hi  output  32  architectural Hi
- lo  output  32  architectural Lo

## Operation
- The FSM has four states: IDLE, MULT, DIV and DONE.
- **IDLE/DONE + start, op=0:** latch a and b and clear the 6-bit counter, then go to MULT.
- **IDLE/DONE + start, op=1, b≠0:** latch |a| and |b| plus both signs, then go to DIV.
- **IDLE/DONE + start, op=1, b==0:** set div_zero=1 and leave the result registers unchanged, then go to DONE.
- **MULT:** 32 shift-add iterations on magnitudes. Each step examines one multiplier bit per cycle.
- **MULT completion:** after iteration 32, apply the sign (negate the 64-bit product if sign(a)≠sign(b)). Store {res_hi,res_lo} = signed a×b (64 bits, exact), then go to DONE.
- **DIV:** 32 restoring iterations on magnitudes, one quotient bit per cycle.
- **DIV completion:** res_lo = quotient truncated toward zero; res_hi = remainder carrying the dividend's sign. Then go to DONE.
- **DIV overflow case:** 0x80000000 / 0xFFFFFFFF yields res_lo=0x80000000 and res_hi=0. This falls out of the magnitude method with no special case.
- **DONE:** done=1 for exactly one cycle. Next state is IDLE, or a new operation if start=1.
- **div_zero:** cleared by any accepted start with b≠0 or op=0. Otherwise it holds.
- **hilo_write=1 in IDLE or DONE:** hi<=res_hi and lo<=res_lo at the clock edge.
  - Ignored when div_zero=1; Hi/Lo keep their previous values.
  - Ignored while busy.
- **start while busy:** ignored; the operation in progress is not disturbed.
- **start + hilo_write in the same DONE cycle:** Hi/Lo commit the just-finished result, and the new operation starts.

## Timing
- **Reset (asynchronous):** state=IDLE. busy, done, div_zero, hi, lo, the result registers and the counter all go to 0 immediately, regardless of clk, including mid-operation.
- **Latency (mult or div):** start sampled at edge E0.
  - busy=1 after E0 through the cycle ending at E32.
  - DONE is entered at E32, so done=1 between E32 and E33.
  - Total: 33 cycles start-to-done.
- **Latency (div by zero):** done=1 in the cycle after E0.
- **Outputs:** hi and lo change only on a hilo_write edge or on reset. res_hi and res_lo are internal and change only on completion.
- **Combinational paths:** none from inputs to outputs. All outputs are registered.

## Structure
- The shared package `mdu_pkg` holds:
  - the state enum (IDLE, MULT, DIV, DONE)
  - the op constants OP_MULT=0 and OP_DIV=1
  - the iteration count localparam MDU_ITER=32
- One combinational sub-module, `mdu_div_step`.
  - Inputs: {remainder, quotient} and the divisor magnitude.
  - Output: the next {remainder, quotient} after one restoring step.
- The multiply step stays inline in `mult_div_unit`.

## Test plan
1. **Signed mult:** mult a=7, b=0xFFFFFFFD (−3), then hilo_write in DONE → done pulse 33 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
2. **Largest negative squared:** mult a=0x80000000, b=0x80000000, then hilo_write → hi=0x40000000, lo=0x00000000.
3. **Signed div:** div a=0xFFFFFFF9 (−7), b=2, then hilo_write → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1); div_zero=0.
4. **Div by zero:** preload Hi/Lo=0x11111111/0x22222222, then div a=5, b=0, then hilo_write → done 1 cycle after start; div_zero=1; hi/lo unchanged.
5. **Div overflow:** div a=0x80000000, b=0xFFFFFFFF, then hilo_write → lo=0x80000000, hi=0.
6. **Reset and busy-start:** assert rst 10 cycles into a mult → all outputs 0 immediately, IDLE. Then start a div; a second start at cycle 5 is ignored and the first result (100/7 → lo=14, hi=2) completes at cycle 33.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multicycle multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  localparam logic OP_MULT  = 1'b0;
  localparam logic OP_DIV   = 1'b1;
  localparam int   MDU_ITER = 32;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step on magnitudes: shift {rem,quo} left, try subtracting the divisor.
// Purely combinational; the caller registers the result each cycle.
module mdu_div_step
  import mdu_pkg::*;
(
  input  logic [63:0] remQuo,
  input  logic [31:0] divisor,
  output logic [63:0] remQuoNext
);

  logic [32:0] shiftedRem;
  logic [32:0] diff;

  // rem < divisor always holds, so the 33-bit trial difference fits back in 32 bits
  assign shiftedRem = {remQuo[63:31]};
  assign diff       = shiftedRem - {1'b0, divisor};

  always_comb begin
    remQuoNext = {shiftedRem[31:0], remQuo[30:0], 1'b0};
    if (!diff[32]) begin
      remQuoNext = {diff[31:0], remQuo[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide with architectural Hi/Lo; 33 cycles start-to-done
// (divide by zero: 1 cycle). Result is held internally until hilo_write commits it.
module mult_div_unit
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hilo_write,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e  state, stateNext;
  logic [5:0]  cnt;
  logic [63:0] work;       // mult: {partial product, remaining multiplier}; div: {rem, quo}
  logic [31:0] operand;    // multiplicand or divisor magnitude
  logic        negRes;     // product / quotient must be negated
  logic        negRem;     // remainder takes the dividend's sign
  logic [31:0] resHi, resLo;

  logic        accept;
  logic        lastIter;
  logic [31:0] magA, magB;
  logic [32:0] multSum;
  logic [63:0] multNext;
  logic [63:0] divNext;
  logic [63:0] prodSigned;
  logic [31:0] quoSigned, remSigned;

  assign magA     = a[31] ? (~a + 32'd1) : a;
  assign magB     = b[31] ? (~b + 32'd1) : b;
  assign lastIter = (cnt == 6'(MDU_ITER - 1));

  assign multSum  = {1'b0, work[63:32]} + (work[0] ? {1'b0, operand} : 33'd0);
  assign multNext = {multSum, work[31:1]};

  mdu_div_step uDivStep (
    .remQuo     (work),
    .divisor    (operand),
    .remQuoNext (divNext)
  );

  assign prodSigned = negRes ? (~multNext + 64'd1) : multNext;
  assign quoSigned  = negRes ? (~divNext[31:0] + 32'd1) : divNext[31:0];
  assign remSigned  = negRem ? (~divNext[63:32] + 32'd1) : divNext[63:32];

  assign busy = (state == MULT) || (state == DIV);
  assign done = (state == DONE);

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (state == DONE) stateNext = IDLE;
        if (start) begin
          accept = 1'b1;
          if (op == OP_MULT)    stateNext = MULT;
          else if (b == 32'd0)  stateNext = DONE;
          else                  stateNext = DIV;
        end
      end
      MULT:    if (lastIter) stateNext = DONE;
      DIV:     if (lastIter) stateNext = DONE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      work     <= '0;
      operand  <= '0;
      negRes   <= 1'b0;
      negRem   <= 1'b0;
      resHi    <= '0;
      resLo    <= '0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      // Commit reads the pre-edge result, so a same-cycle restart still commits the old one
      if ((state == IDLE || state == DONE) && hilo_write && !div_zero) begin
        hi <= resHi;
        lo <= resLo;
      end
      if (accept) begin
        cnt    <= '0;
        negRes <= a[31] ^ b[31];
        negRem <= a[31];
        if (op == OP_MULT) begin
          div_zero <= 1'b0;
          operand  <= magA;
          work     <= {32'd0, magB};
        end else if (b == 32'd0) begin
          div_zero <= 1'b1;
        end else begin
          div_zero <= 1'b0;
          operand  <= magB;
          work     <= {32'd0, magA};
        end
      end else if (state == MULT) begin
        cnt  <= cnt + 6'd1;
        work <= multNext;
        if (lastIter) begin
          resHi <= prodSigned[63:32];
          resLo <= prodSigned[31:0];
        end
      end else if (state == DIV) begin
        cnt  <= cnt + 6'd1;
        work <= divNext;
        if (lastIter) begin
          resHi <= remSigned;
          resLo <= quoSigned;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed vectors checked with immediate assertions.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hilo_write = 1'b0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int lat;

  mult_div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .hilo_write (hilo_write),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is first seen (lat = cycles after start edge).
  task automatic runOp(input logic o, input logic [31:0] x, input logic [31:0] y, output int l);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    l = 1;
    while (!done && l < 40) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic commit();
    hilo_write = 1'b1;
    @(negedge clk);
    hilo_write = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_divz", {31'd0, div_zero}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 7 * -3
    start = 1'b1; op = 1'b0; a = 32'd7; b = 32'hFFFF_FFFD;
    @(negedge clk);
    start = 1'b0;
    chk("mul1_busy", {31'd0, busy}, 32'd1);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("mul1_lat", 32'(lat), 32'd33);
    chk("mul1_hi_before", hi, 32'd0);
    commit();
    chk("mul1_done_pulse", {31'd0, done}, 32'd0);
    chk("mul1_hi", hi, 32'hFFFF_FFFF);
    chk("mul1_lo", lo, 32'hFFFF_FFEB);

    // 0x80000000 squared
    runOp(1'b0, 32'h8000_0000, 32'h8000_0000, lat);
    commit();
    chk("mul2_hi", hi, 32'h4000_0000);
    chk("mul2_lo", lo, 32'h0000_0000);

    // -7 / 2
    runOp(1'b1, 32'hFFFF_FFF9, 32'd2, lat);
    chk("div1_lat", 32'(lat), 32'd33);
    chk("div1_hi_before", hi, 32'h4000_0000);
    commit();
    chk("div1_lo", lo, 32'hFFFF_FFFD);
    chk("div1_hi", hi, 32'hFFFF_FFFF);
    chk("div1_divz", {31'd0, div_zero}, 32'd0);

    // preload 0x11111111_22222222 = 0x55555556 * 0x33333333
    runOp(1'b0, 32'h5555_5556, 32'h3333_3333, lat);
    commit();
    chk("pre_hi", hi, 32'h1111_1111);
    chk("pre_lo", lo, 32'h2222_2222);

    // divide by zero
    runOp(1'b1, 32'd5, 32'd0, lat);
    chk("dz_lat", 32'(lat), 32'd1);
    chk("dz_flag", {31'd0, div_zero}, 32'd1);
    commit();
    chk("dz_hi", hi, 32'h1111_1111);
    chk("dz_lo", lo, 32'h2222_2222);
    chk("dz_flag_hold", {31'd0, div_zero}, 32'd1);

    // overflow divide; start + commit together in DONE exercises the restart path
    runOp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    chk("ovf_divz_clr", {31'd0, div_zero}, 32'd0);
    chk("ovf_lat", 32'(lat), 32'd33);
    hilo_write = 1'b1; start = 1'b1; op = 1'b0; a = 32'd6; b = 32'd5;
    @(negedge clk);
    hilo_write = 1'b0; start = 1'b0;
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0000_0000);
    chk("restart_busy", {31'd0, busy}, 32'd1);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("restart_lat", 32'(lat), 32'd33);
    commit();
    chk("restart_lo", lo, 32'd30);
    chk("restart_hi", hi, 32'd0);

    // asynchronous reset 10 cycles into a mult
    start = 1'b1; op = 1'b0; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_idle", {30'd0, busy, done}, 32'd0);

    // 100 / 7 with a competing start while busy
    start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      if (lat == 5) begin
        start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("busy_lat", 32'(lat), 32'd33);
    commit();
    chk("busy_lo", lo, 32'd14);
    chk("busy_hi", hi, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
